// File: rtl/rr_arb_pkg.sv
// Shared types and defaults for the round-robin index arbiter.
// Holds the arbiter state encoding and the default index width.
package rr_arb_pkg;

    localparam int RR_IDX_WIDTH = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority finder: first set request at or after start_i, wrapping modulo N_REQ.
// Purely combinational; no latency and no flow control of its own.
module rr_priority_pick
    import rr_arb_pkg::*;
#(
    parameter  int IDX_WIDTH = RR_IDX_WIDTH,
    localparam int N_REQ     = 1 << IDX_WIDTH
) (
    input  logic [N_REQ-1:0]     req_i,
    input  logic [IDX_WIDTH-1:0] start_i,
    output logic                 hit_o,
    output logic [IDX_WIDTH-1:0] idx_o
);

    logic [IDX_WIDTH-1:0] pos;

    // Scan from the far end back toward start_i so the nearest hit is written last.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        pos   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            pos = start_i + IDX_WIDTH'(k);
            if (req_i[pos]) begin
                hit_o = 1'b1;
                idx_o = pos;
            end
        end
    end

endmodule

// File: rtl/rr_index_arbiter.sv
// Round-robin arbiter with registered binary grant; req at edge n -> valid_o at edge n+1, back-to-back on handshake.
// Grant holds while ready_i=0; optional multi-beat hold via lock_i when RR_ARB_LOCK_EN is defined.
module rr_index_arbiter
    import rr_arb_pkg::*;
#(
    parameter  int IDX_WIDTH = RR_IDX_WIDTH,
    localparam int N_REQ     = 1 << IDX_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_i,
    input  logic                 ready_i,
    output logic [IDX_WIDTH-1:0] idx_o,
    output logic                 valid_o,
    output logic                 dec_en_o
`ifdef RR_ARB_LOCK_EN
    ,
    input  logic                 lock_i
`endif
);

    arb_state_t           state_q, state_d;
    logic [IDX_WIDTH-1:0] ptr_q, ptr_d;
    logic [IDX_WIDTH-1:0] idx_q, idx_d;

    logic                 lock_w;
    logic [N_REQ-1:0]     served_mask;
    logic [N_REQ-1:0]     pick_req;
    logic [IDX_WIDTH-1:0] pick_start;
    logic                 pick_hit;
    logic [IDX_WIDTH-1:0] pick_idx;

`ifdef RR_ARB_LOCK_EN
    assign lock_w = lock_i;
`else
    assign lock_w = 1'b0;
`endif

    // While granting, the only time the pick is consumed is a handshake, so the
    // just-served line is masked and the scan starts right after it.
    always_comb begin
        served_mask = {{(N_REQ-1){1'b0}}, 1'b1} << idx_q;
        pick_req    = req_i;
        pick_start  = ptr_q;
        if (state_q == GRANT) begin
            pick_req   = req_i & ~served_mask;
            pick_start = idx_q + 1'b1;
        end
    end

    rr_priority_pick #(
        .IDX_WIDTH (IDX_WIDTH)
    ) u_pick (
        .req_i   (pick_req),
        .start_i (pick_start),
        .hit_o   (pick_hit),
        .idx_o   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (pick_hit) begin
                    idx_d   = pick_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (ready_i && !lock_w) begin
                    ptr_d = idx_q + 1'b1;
                    if (pick_hit) begin
                        idx_d = pick_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
        end
    end

    assign idx_o    = idx_q;
    assign valid_o  = (state_q == GRANT);
    assign dec_en_o = valid_o;

endmodule

// File: tb/tb_rr_index_arbiter.sv
// Scenario bench for rr_index_arbiter: handshaked grants are scored against a queue of expected indices.
module tb_rr_index_arbiter;

    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   req_i = '0;
    logic          ready_i = 1'b0;
    logic [IW-1:0] idx_o;
    logic          valid_o;
    logic          dec_en_o;
`ifdef RR_ARB_LOCK_EN
    logic          lock_i = 1'b0;
`endif

    int            checks = 0;
    int            errors = 0;
    logic [IW-1:0] exp_q[$];
    logic [IW-1:0] exp_idx;

    rr_index_arbiter #(.IDX_WIDTH(IW)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req_i),
        .ready_i  (ready_i),
        .idx_o    (idx_o),
        .valid_o  (valid_o),
        .dec_en_o (dec_en_o)
`ifdef RR_ARB_LOCK_EN
        ,
        .lock_i   (lock_i)
`endif
    );

    always #5 clk = ~clk;

    // Every handshake (valid & ready seen mid-cycle) consumes one expected grant.
    always @(negedge clk) begin
        if (!rst && valid_o && ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow: handshake on idx %0d, nothing expected", idx_o);
            end else begin
                exp_idx = exp_q.pop_front();
                if (idx_o !== exp_idx) begin
                    errors++;
                    $display("FAIL sb_grant: idx_o=%0d expected %0d", idx_o, exp_idx);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_i   = '0;
        ready_i = 1'b0;
        rst     = 1'b1;
        #2;
        rst     = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        checks++;
        if (valid_o !== 1'b0 || idx_o !== 5'd0 || dec_en_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%b idx=%0d en=%b expected 0/0/0", valid_o, idx_o, dec_en_o);
        end
        do_reset();
        req_i = 32'h0000_0200;
        cyc();
        checks++;
        if (valid_o !== 1'b1 || idx_o !== 5'd9) begin
            errors++;
            $display("FAIL pre_reset_grant: valid=%b idx=%0d expected 1/9", valid_o, idx_o);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (valid_o !== 1'b0 || idx_o !== 5'd0 || dec_en_o !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: valid=%b idx=%0d en=%b expected 0/0/0", valid_o, idx_o, dec_en_o);
        end
        rst   = 1'b0;
        req_i = 32'h0000_0010;
        cyc();
        checks++;
        if (valid_o !== 1'b1 || idx_o !== 5'd4 || dec_en_o !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_grant: valid=%b idx=%0d en=%b expected 1/4/1", valid_o, idx_o, dec_en_o);
        end
        exp_q.push_back(5'd4);
        req_i   = '0;
        ready_i = 1'b1;
        cyc();
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: valid=%b expected 0", valid_o);
        end
    endtask

    task automatic test_idle();
        do_reset();
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (valid_o !== 1'b0 || idx_o !== 5'd0) begin
                errors++;
                $display("FAIL idle_stable: valid=%b idx=%0d expected 0/0", valid_o, idx_o);
            end
        end
    endtask

    task automatic test_alternate();
        do_reset();
        for (int i = 0; i < 6; i++) exp_q.push_back((i % 2 == 0) ? 5'd0 : 5'd31);
        req_i   = 32'h8000_0001;
        ready_i = 1'b1;
        cyc();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (valid_o !== 1'b1) begin
                errors++;
                $display("FAIL alt_no_bubble: beat %0d valid=%b expected 1", i, valid_o);
            end
            if (i == 5) req_i = '0;
            cyc();
        end
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL alt_drain: valid=%b expected 0", valid_o);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        exp_q.push_back(5'd30);
        exp_q.push_back(5'd1);
        exp_q.push_back(5'd2);
        req_i = 32'h4000_0000;
        cyc();
        checks++;
        if (idx_o !== 5'd30 || valid_o !== 1'b1) begin
            errors++;
            $display("FAIL wrap_setup: idx=%0d valid=%b expected 30/1", idx_o, valid_o);
        end
        req_i   = 32'h0000_0006;
        ready_i = 1'b1;
        cyc();
        checks++;
        if (idx_o !== 5'd1 || valid_o !== 1'b1) begin
            errors++;
            $display("FAIL wrap_first: idx=%0d valid=%b expected 1/1", idx_o, valid_o);
        end
        cyc();
        checks++;
        if (idx_o !== 5'd2 || valid_o !== 1'b1) begin
            errors++;
            $display("FAIL wrap_second: idx=%0d valid=%b expected 2/1", idx_o, valid_o);
        end
        req_i = '0;
        cyc();
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL wrap_drain: valid=%b expected 0", valid_o);
        end
    endtask

    task automatic test_hold();
        do_reset();
        req_i = 32'h0000_0080;
        cyc();
        req_i = '0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            checks++;
            if (idx_o !== 5'd7 || valid_o !== 1'b1) begin
                errors++;
                $display("FAIL hold_stall: cycle %0d idx=%0d valid=%b expected 7/1", i, idx_o, valid_o);
            end
        end
        exp_q.push_back(5'd7);
        ready_i = 1'b1;
        cyc();
        checks++;
        if (valid_o !== 1'b0 || dec_en_o !== 1'b0 || idx_o !== 5'd7) begin
            errors++;
            $display("FAIL hold_release: valid=%b en=%b idx=%0d expected 0/0/7", valid_o, dec_en_o, idx_o);
        end
    endtask

    task automatic test_sweep();
        do_reset();
        for (int i = 0; i < 32; i++) exp_q.push_back(IW'(i));
        req_i   = 32'hFFFF_FFFF;
        ready_i = 1'b1;
        cyc();
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (valid_o !== 1'b1 || idx_o !== IW'(i)) begin
                errors++;
                $display("FAIL sweep_order: beat %0d idx=%0d valid=%b expected %0d/1", i, idx_o, valid_o, i);
            end
            if (i == 31) req_i = '0;
            cyc();
        end
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL sweep_drain: valid=%b expected 0", valid_o);
        end
    endtask

`ifdef RR_ARB_LOCK_EN
    task automatic test_lock();
        do_reset();
        req_i = 32'h0000_0008;
        cyc();
        for (int i = 0; i < 4; i++) exp_q.push_back(5'd3);
        req_i   = 32'hFFFF_FFFF;
        lock_i  = 1'b1;
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (idx_o !== 5'd3 || valid_o !== 1'b1) begin
                errors++;
                $display("FAIL lock_hold: beat %0d idx=%0d valid=%b expected 3/1", i, idx_o, valid_o);
            end
        end
        lock_i = 1'b0;
        cyc();
        checks++;
        if (idx_o !== 5'd4 || valid_o !== 1'b1) begin
            errors++;
            $display("FAIL lock_release: idx=%0d valid=%b expected 4/1", idx_o, valid_o);
        end
        exp_q.push_back(5'd4);
        req_i = '0;
        cyc();
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL lock_drain: valid=%b expected 0", valid_o);
        end
    endtask
`endif

    initial begin
        #1;
        test_reset();
        test_idle();
        test_alternate();
        test_wrap();
        test_hold();
        test_sweep();
`ifdef RR_ARB_LOCK_EN
        test_lock();
`endif
        cyc();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d expected grants never handshaked, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
